// File: rtl/multi_byte_adder_seq_pkg.sv
// Shared definitions for the sequential multi-byte adder.
//   state_t  : FSM encoding (IDLE / RUN / DONE)
//   BYTE_W   : width of one adder slice
//   idx_width: byte-index counter width, never less than one bit
package multi_byte_adder_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int n_bytes);
        return (n_bytes > 1) ? $clog2(n_bytes) : 1;
    endfunction

endpackage

// File: rtl/cla_adder_8bits.sv
// 8-bit carry-lookahead adder slice.
//   a, b : 8-bit operands
//   cin  : carry in
//   sum  : a + b + cin (low 8 bits)
//   cout : carry out of bit 7
module cla_adder_8bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flat sum-of-products of generate terms and the
    // propagate chain above them, so no carry depends on a lower carry.
    always_comb begin
        logic acc;
        logic prod;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            prod = cin;
            for (int j = 0; j <= i; j++) begin
                prod = prod & p[j];
            end
            acc = prod;
            for (int k = 0; k <= i; k++) begin
                prod = g[k];
                for (int m = k + 1; m <= i; m++) begin
                    prod = prod & p[m];
                end
                acc = acc | prod;
            end
            c[i+1] = acc;
        end
    end

    assign sum  = p ^ c[7:0];
    assign cout = c[8];

endmodule

// File: rtl/multi_byte_adder_seq.sv
// Sequential wide adder: one operand pair per transaction, summed one byte
// per cycle (LSB first) through a single 8-bit CLA slice.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : operand handshake (a, b, cin)
//   out_valid/out_ready   : result handshake (sum, cout, ovf)
//   busy                  : transaction in RUN or DONE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a new operand pair
// RUN   | one byte added per cycle, carry held in carry_reg
// DONE  | result presented, waiting for out_ready
module multi_byte_adder_seq
    import multi_byte_adder_seq_pkg::*;
#(
    parameter int N_BYTES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BYTE_W*N_BYTES-1:0] a,
    input  logic [BYTE_W*N_BYTES-1:0] b,
    input  logic                      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BYTE_W*N_BYTES-1:0] sum,
    output logic                      cout,
    output logic                      ovf,
    output logic                      busy
);

    localparam int W     = BYTE_W * N_BYTES;
    localparam int IDX_W = idx_width(N_BYTES);

    state_t             state;
    state_t             state_nxt;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [W-1:0]       sum_sh;
    logic [W-1:0]       sum_sh_nxt;
    logic               a_msb;
    logic               b_msb;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       sum_q;
    logic               cout_q;
    logic               ovf_q;
    logic [BYTE_W-1:0]  byte_sum;
    logic               byte_cout;
    logic               accept;
    logic               last_byte;

    cla_adder_8bits u_slice (
        .a    (a_sh[BYTE_W-1:0]),
        .b    (b_sh[BYTE_W-1:0]),
        .cin  (carry_reg),
        .sum  (byte_sum),
        .cout (byte_cout)
    );

    assign accept     = (state == IDLE) && in_valid;
    assign last_byte  = (idx == IDX_W'(N_BYTES - 1));
    // Shifting through a widened vector keeps this legal for N_BYTES = 1.
    assign sum_sh_nxt = W'({byte_sum, sum_sh} >> BYTE_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_byte) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            a_sh      <= a;
            b_sh      <= b;
            a_msb     <= a[W-1];
            b_msb     <= b[W-1];
            carry_reg <= cin;
            idx       <= '0;
        end else if (state == RUN) begin
            a_sh      <= a_sh >> BYTE_W;
            b_sh      <= b_sh >> BYTE_W;
            sum_sh    <= sum_sh_nxt;
            carry_reg <= byte_cout;
            idx       <= idx + 1'b1;
            // Result registers load only here so they hold across the
            // next RUN instead of showing the shifting partial sum.
            if (last_byte) begin
                sum_q  <= sum_sh_nxt;
                cout_q <= byte_cout;
                ovf_q  <= (a_msb == b_msb) && (sum_sh_nxt[W-1] != a_msb);
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_multi_byte_adder_seq.sv
module tb_multi_byte_adder_seq;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    logic        in_valid_1;
    logic        in_ready_1;
    logic [7:0]  a_1;
    logic [7:0]  b_1;
    logic        cin_1;
    logic        out_valid_1;
    logic        out_ready_1;
    logic [7:0]  sum_1;
    logic        cout_1;
    logic        ovf_1;
    logic        busy_1;

    int n_checks;
    int n_errors;

    multi_byte_adder_seq #(.N_BYTES(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    multi_byte_adder_seq #(.N_BYTES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_1),
        .in_ready  (in_ready_1),
        .a         (a_1),
        .b         (b_1),
        .cin       (cin_1),
        .out_valid (out_valid_1),
        .out_ready (out_ready_1),
        .sum       (sum_1),
        .cout      (cout_1),
        .ovf       (ovf_1),
        .busy      (busy_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full 4-byte transaction; caller sits #1 after a rising edge.
    task automatic run4(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tcin, input logic [31:0] es, input logic ec, input logic eo);
        int cyc;
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        cin      = tcin;
        cyc      = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_wait_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            chk({tag, "_inrdy_run"}, 64'(in_ready), 64'(0));
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(4));
        chk({tag, "_sum"}, 64'(sum), 64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
        chk({tag, "_inrdy_done"}, 64'(in_ready), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 64'(out_valid), 64'(0));
        chk({tag, "_idle"}, 64'(in_ready), 64'(1));
    endtask

    task automatic run1(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tcin, input logic [7:0] es, input logic ec, input logic eo);
        int cyc;
        in_valid_1 = 1'b1;
        a_1        = ta;
        b_1        = tb_v;
        cin_1      = tcin;
        chk({tag, "_ready"}, 64'(in_ready_1), 64'(1));
        @(posedge clk); #1;
        in_valid_1 = 1'b0;
        cyc = 0;
        while (!out_valid_1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(1));
        chk({tag, "_sum"}, 64'(sum_1), 64'(es));
        chk({tag, "_cout"}, 64'(cout_1), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf_1), 64'(eo));
        out_ready_1 = 1'b1;
        @(posedge clk); #1;
        out_ready_1 = 1'b0;
        chk({tag, "_ov_drop"}, 64'(out_valid_1), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] ref_full;
        logic        ref_ovf;

        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        out_ready   = 1'b0;
        in_valid_1  = 1'b0;
        a_1         = '0;
        b_1         = '0;
        cin_1       = 1'b0;
        out_ready_1 = 1'b0;

        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_in_ready_1", 64'(in_ready_1), 64'(1));

        run4("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run4("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run4("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        run4("cin1",   32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 32'h2143_6588, 1'b0, 1'b0);

        // Backpressure with a second pair pending on the input.
        in_valid = 1'b1;
        a        = 32'h0000_0005;
        b        = 32'h0000_000A;
        cin      = 1'b0;
        @(posedge clk); #1;
        a = 32'h8000_0001;
        b = 32'hFFFF_FFFF;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_latency", 64'(cyc), 64'(4));
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_sum", 64'(sum), 64'(32'h0000_000F));
            chk("bp_cout", 64'(cout), 64'(0));
            chk("bp_ovf", 64'(ovf), 64'(0));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_ov_drop", 64'(out_valid), 64'(0));
        chk("bp_idle_ready", 64'(in_ready), 64'(1));
        chk("bp_sum_hold", 64'(sum), 64'(32'h0000_000F));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp2_accept_busy", 64'(busy), 64'(1));
        chk("bp2_accept_ready", 64'(in_ready), 64'(0));
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp2_latency", 64'(cyc), 64'(4));
        chk("bp2_sum", 64'(sum), 64'(32'h8000_0000));
        chk("bp2_cout", 64'(cout), 64'(1));
        chk("bp2_ovf", 64'(ovf), 64'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp2_ov_drop", 64'(out_valid), 64'(0));

        // Asynchronous reset while RUN is at byte index 2.
        in_valid = 1'b1;
        a        = 32'hFFFF_FFFF;
        b        = 32'h0000_0001;
        cin      = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk("mid_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", 64'(in_ready), 64'(1));
        chk("mrst_out_valid", 64'(out_valid), 64'(0));
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_sum", 64'(sum), 64'(0));
        chk("mrst_cout", 64'(cout), 64'(0));
        chk("mrst_ovf", 64'(ovf), 64'(0));
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_no_pulse", 64'(out_valid), 64'(0));
        run4("post_rst", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

        run1("n1_ff01", 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
        run1("n1_7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra       = $urandom;
            rb       = $urandom;
            rc       = 1'($urandom_range(0, 1));
            ref_full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            ref_ovf  = (ra[31] == rb[31]) && (ref_full[31] != ra[31]);
            run4("rand", ra, rb, rc, ref_full[31:0], ref_full[32], ref_ovf);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
